// File: rtl/mem_responder_if.sv
// Request/answer bundle between the data cache (master) and the memory model (slave).
interface mem_responder_if #(
  parameter int BLK_WIDTH = 64,
  parameter int IDX_WIDTH = 10,
  parameter int TAG_WIDTH = 4
);
  logic [1:0]           qry_cmd;
  logic [IDX_WIDTH-1:0] qry_idx;
  logic [BLK_WIDTH-1:0] qry_blk;
  logic [TAG_WIDTH-1:0] ack;
  logic [TAG_WIDTH-1:0] ans_tag;
  logic [BLK_WIDTH-1:0] ans_blk;

  modport master (output qry_cmd, qry_idx, qry_blk, input ack, ans_tag, ans_blk);
  modport slave  (input qry_cmd, qry_idx, qry_blk, output ack, ans_tag, ans_blk);
endinterface

// File: rtl/mem_responder.sv
// Fixed-latency in-order main-memory model behind the data cache.
// Optional command/answer trace when MEM_RESPONDER_TRACE_EN is defined.
module mem_responder #(
  parameter int BLK_WIDTH = 64,
  parameter int IDX_WIDTH = 10,
  parameter int TAG_WIDTH = 4,
  parameter int LATENCY   = 4
) (
  input  logic           clock,
  input  logic           reset,
  mem_responder_if.slave bus
);
  localparam int                   DEPTH    = 2**TAG_WIDTH;
  localparam logic [TAG_WIDTH-1:0] MAX_TAG  = {TAG_WIDTH{1'b1}};
  localparam logic [TAG_WIDTH-1:0] TAG_ONE  = {{(TAG_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [TAG_WIDTH-1:0] TAG_ZERO = {TAG_WIDTH{1'b0}};
  localparam logic [BLK_WIDTH-1:0] BLK_ZERO = {BLK_WIDTH{1'b0}};
  localparam logic [4:0]           DUE_OFS  = 5'(LATENCY - 1);
  localparam logic [1:0]           CMD_LOAD  = 2'd1;
  localparam logic [1:0]           CMD_STORE = 2'd2;
  // Latency 1 answers straight from the acceptance edge and never queues.
  localparam bit                   USE_FIFO = (LATENCY > 1);

  logic [BLK_WIDTH-1:0] mem_r      [2**IDX_WIDTH];
  logic [TAG_WIDTH-1:0] fifo_tag_r [DEPTH];
  logic [BLK_WIDTH-1:0] fifo_blk_r [DEPTH];
  logic [4:0]           fifo_due_r [DEPTH];

  logic [TAG_WIDTH-1:0] wr_ptr_r, rd_ptr_r, count_r, next_tag_r;
  logic [4:0]           cyc_r;
  logic [TAG_WIDTH-1:0] ans_tag_r;
  logic [BLK_WIDTH-1:0] ans_blk_r;

  logic [TAG_WIDTH-1:0] ack_s;
  logic                 load_acc_s, store_acc_s, push_s, pop_s;
  logic [4:0]           head_age_s;
  logic [BLK_WIDTH-1:0] rd_blk_s;

  // Command decode and Mealy acknowledge; count is taken before any pop this cycle.
  always_comb begin
    ack_s       = TAG_ZERO;
    load_acc_s  = 1'b0;
    store_acc_s = 1'b0;
    if (!reset) begin
      ack_s = TAG_ZERO;
    end else begin
      case (bus.qry_cmd)
        CMD_LOAD: begin
          if (count_r < MAX_TAG) begin
            ack_s      = next_tag_r;
            load_acc_s = 1'b1;
          end else begin
            ack_s = TAG_ZERO;
          end
        end
        CMD_STORE: begin
          ack_s       = next_tag_r;
          store_acc_s = 1'b1;
        end
        default: ack_s = TAG_ZERO;
      endcase
    end
  end

  // Head is due once the cycle counter has reached its due stamp (sign of the 5-bit difference).
  always_comb begin
    rd_blk_s   = mem_r[bus.qry_idx];
    push_s     = load_acc_s & USE_FIFO;
    head_age_s = cyc_r - fifo_due_r[rd_ptr_r];
    pop_s      = (count_r != TAG_ZERO) && (head_age_s[4] == 1'b0);
  end

  // Backing storage; deliberately not reset so contents survive a reset.
  always_ff @(posedge clock) begin
    if (store_acc_s) begin
      mem_r[bus.qry_idx] <= bus.qry_blk;
    end
  end

  // Pending-load payload; data is snapshotted here so later stores cannot alter it.
  always_ff @(posedge clock) begin
    if (push_s) begin
      fifo_tag_r[wr_ptr_r] <= next_tag_r;
      fifo_blk_r[wr_ptr_r] <= rd_blk_s;
      fifo_due_r[wr_ptr_r] <= cyc_r + DUE_OFS;
    end
  end

  // Queue pointers, tag allocator, cycle counter and registered answer port.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_r   <= TAG_ZERO;
      rd_ptr_r   <= TAG_ZERO;
      count_r    <= TAG_ZERO;
      next_tag_r <= TAG_ONE;
      cyc_r      <= 5'd0;
      ans_tag_r  <= TAG_ZERO;
      ans_blk_r  <= BLK_ZERO;
    end else begin
      cyc_r <= cyc_r + 5'd1;
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + TAG_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + TAG_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + TAG_ONE;
        2'b01:   count_r <= count_r - TAG_ONE;
        default: count_r <= count_r;
      endcase
      if (load_acc_s) begin
        next_tag_r <= (next_tag_r == MAX_TAG) ? TAG_ONE : next_tag_r + TAG_ONE;
      end
      if (load_acc_s && !USE_FIFO) begin
        ans_tag_r <= next_tag_r;
        ans_blk_r <= rd_blk_s;
      end else if (pop_s) begin
        ans_tag_r <= fifo_tag_r[rd_ptr_r];
        ans_blk_r <= fifo_blk_r[rd_ptr_r];
      end else begin
        ans_tag_r <= TAG_ZERO;
        ans_blk_r <= BLK_ZERO;
      end
    end
  end

  assign bus.ack     = ack_s;
  assign bus.ans_tag = ans_tag_r;
  assign bus.ans_blk = ans_blk_r;

`ifdef MEM_RESPONDER_TRACE_EN
  // Simulation trace of accepted commands and presented answers.
  always @(posedge clock) begin
    if (reset) begin
      if (bus.qry_cmd == 2'd3) begin
        $error("mem_responder: illegal qry_cmd=3 at cycle %0d", cyc_r);
      end
      if (load_acc_s) begin
        $display("mem_responder cyc=%0d LOAD idx=%0h tag=%0d", cyc_r, bus.qry_idx, ack_s);
      end
      if (store_acc_s) begin
        $display("mem_responder cyc=%0d STORE idx=%0h tag=%0d data=%h", cyc_r, bus.qry_idx, ack_s,
                 bus.qry_blk);
      end
      if (ans_tag_r != TAG_ZERO) begin
        $display("mem_responder cyc=%0d ANSWER tag=%0d data=%h", cyc_r, ans_tag_r, ans_blk_r);
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench: latency-4 instance for the basic flows, latency-16 instance for the full-queue case.
module tb_mem_responder;
  logic clock;
  logic rst_a, rst_b;
  int   n_vec = 0;
  int   n_err = 0;

  localparam logic [1:0] NONE = 2'd0, LOAD = 2'd1, STORE = 2'd2;
  localparam logic [63:0] D2  = 64'hdeadbeefcc00ffee;
  localparam logic [63:0] D5  = 64'h5555_0000_1111_aaaa;
  localparam logic [63:0] D6  = 64'h6666_1234_5678_9abc;
  localparam logic [63:0] D6N = 64'h0606_0606_0606_0606;
  localparam logic [63:0] D7  = 64'h7777_fedc_ba98_7654;
  localparam logic [63:0] D9  = 64'h9999_0000_9999_0000;

  mem_responder_if #(.BLK_WIDTH(64), .IDX_WIDTH(10), .TAG_WIDTH(4)) a_if ();
  mem_responder_if #(.BLK_WIDTH(64), .IDX_WIDTH(10), .TAG_WIDTH(4)) b_if ();

  mem_responder #(.BLK_WIDTH(64), .IDX_WIDTH(10), .TAG_WIDTH(4), .LATENCY(4)) dut (
    .clock(clock), .reset(rst_a), .bus(a_if)
  );
  mem_responder #(.BLK_WIDTH(64), .IDX_WIDTH(10), .TAG_WIDTH(4), .LATENCY(16)) dut16 (
    .clock(clock), .reset(rst_b), .bus(b_if)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_a(input logic [1:0] cmd, input logic [9:0] idx, input logic [63:0] blk);
    a_if.qry_cmd = cmd;
    a_if.qry_idx = idx;
    a_if.qry_blk = blk;
    #1;
  endtask

  task automatic chk_ans_a(input string tag, input logic [3:0] t, input logic [63:0] d);
    chk({tag, "_tag"}, 64'(a_if.ans_tag), 64'(t));
    chk({tag, "_blk"}, a_if.ans_blk, d);
  endtask

  initial begin
    logic [63:0] exp_ack, exp_tag;
    rst_a = 1'b0;
    rst_b = 1'b0;
    a_if.qry_cmd = NONE; a_if.qry_idx = 10'd0; a_if.qry_blk = 64'd0;
    b_if.qry_cmd = NONE; b_if.qry_idx = 10'd0; b_if.qry_blk = 64'd0;

    // Reset for two edges
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_ack", 64'(a_if.ack), 64'd0);
      chk_ans_a("rst_ans", 4'd0, 64'd0);
    end
    rst_a = 1'b1;

    // Store then load idx 2, answer exactly four edges from the load cycle
    drive_a(STORE, 10'd2, D2);
    chk("st2_ack", 64'(a_if.ack), 64'd1);
    tick();
    drive_a(LOAD, 10'd2, 64'd0);
    chk("ld2_ack", 64'(a_if.ack), 64'd1);
    tick();
    drive_a(NONE, 10'd0, 64'd0);
    for (int i = 0; i < 3; i++) begin
      chk_ans_a("ld2_wait", 4'd0, 64'd0);
      tick();
    end
    chk_ans_a("ld2_ans", 4'd1, D2);
    tick();
    chk_ans_a("ld2_after", 4'd0, 64'd0);

    // Cmd 3 behaves as NONE
    drive_a(2'd3, 10'd2, 64'd0);
    chk("cmd3_ack", 64'(a_if.ack), 64'd0);
    tick();

    // Preload idx 5,6,7 (next_tag is 2, stores do not advance it)
    drive_a(STORE, 10'd5, D5); chk("st5_ack", 64'(a_if.ack), 64'd2); tick();
    drive_a(STORE, 10'd6, D6); chk("st6_ack", 64'(a_if.ack), 64'd2); tick();
    drive_a(STORE, 10'd7, D7); chk("st7_ack", 64'(a_if.ack), 64'd2); tick();
    drive_a(NONE, 10'd0, 64'd0);
    rst_a = 1'b0;
    tick();
    rst_a = 1'b1;

    // Back-to-back loads, store after acceptance, then load-after-store
    drive_a(LOAD, 10'd5, 64'd0); chk("x0_ack", 64'(a_if.ack), 64'd1); chk_ans_a("x0", 4'd0, 64'd0); tick();
    drive_a(LOAD, 10'd6, 64'd0); chk("x1_ack", 64'(a_if.ack), 64'd2); chk_ans_a("x1", 4'd0, 64'd0); tick();
    drive_a(LOAD, 10'd7, 64'd0); chk("x2_ack", 64'(a_if.ack), 64'd3); chk_ans_a("x2", 4'd0, 64'd0); tick();
    drive_a(STORE, 10'd6, D6N);  chk("x3_ack", 64'(a_if.ack), 64'd4); chk_ans_a("x3", 4'd0, 64'd0); tick();
    drive_a(LOAD, 10'd6, 64'd0); chk("x4_ack", 64'(a_if.ack), 64'd4); chk_ans_a("x4", 4'd1, D5); tick();
    drive_a(NONE, 10'd0, 64'd0);
    chk_ans_a("x5", 4'd2, D6); tick();
    chk_ans_a("x6", 4'd3, D7); tick();
    chk_ans_a("x7", 4'd0, 64'd0); tick();
    chk_ans_a("x8", 4'd4, D6N); tick();
    chk_ans_a("x9", 4'd0, 64'd0);

    // Reset while three loads are in flight
    drive_a(LOAD, 10'd5, 64'd0); chk("y0_ack", 64'(a_if.ack), 64'd5); tick();
    drive_a(LOAD, 10'd6, 64'd0); chk("y1_ack", 64'(a_if.ack), 64'd6); tick();
    drive_a(LOAD, 10'd7, 64'd0); chk("y2_ack", 64'(a_if.ack), 64'd7); tick();
    rst_a = 1'b0;
    drive_a(LOAD, 10'd7, 64'd0);
    chk("y3_ack_in_reset", 64'(a_if.ack), 64'd0);
    tick();
    rst_a = 1'b1;
    drive_a(LOAD, 10'd2, 64'd0);
    chk("y4_ack", 64'(a_if.ack), 64'd1);
    chk_ans_a("y4", 4'd0, 64'd0);
    tick();
    drive_a(NONE, 10'd0, 64'd0);
    for (int i = 0; i < 3; i++) begin
      chk_ans_a("y_drop", 4'd0, 64'd0);
      tick();
    end
    chk_ans_a("y8", 4'd1, D2);
    tick();
    chk_ans_a("y9", 4'd0, 64'd0);

    // Latency-16 instance: fill to 15 outstanding, 16th stalls until the first answer cycle
    rst_b = 1'b1;
    b_if.qry_cmd = STORE; b_if.qry_idx = 10'd9; b_if.qry_blk = D9;
    #1;
    chk("b_st9_ack", 64'(b_if.ack), 64'd1);
    tick();
    b_if.qry_cmd = LOAD; b_if.qry_blk = 64'd0;
    for (int k = 0; k <= 32; k++) begin
      if (k == 17) b_if.qry_cmd = NONE;
      #1;
      if (k < 15)       exp_ack = 64'(k + 1);
      else if (k == 16) exp_ack = 64'd1;
      else              exp_ack = 64'd0;
      if (k < 16)       exp_tag = 64'd0;
      else if (k <= 30) exp_tag = 64'(k - 15);
      else if (k == 31) exp_tag = 64'd0;
      else              exp_tag = 64'd1;
      chk($sformatf("full_ack_k%0d", k), 64'(b_if.ack), exp_ack);
      chk($sformatf("full_tag_k%0d", k), 64'(b_if.ans_tag), exp_tag);
      chk($sformatf("full_blk_k%0d", k), b_if.ans_blk, (exp_tag != 64'd0) ? D9 : 64'd0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
